// File: rtl/reduce_r_pkg.sv
// reduce_r package: op encodings, identity values and tree sizing helpers.
// Sizing helpers are constant functions used at elaboration time only.
package reduce_r_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_XNOR = 2'b11
  } op_e;

  // Identity element: 1 for AND, 0 for OR/XOR/XNOR.
  function automatic logic id_of(input logic [1:0] op);
    return (op == OP_AND);
  endfunction

  // max(1, ceil(log_radix(width))).
  function automatic int clog_radix(input int width, input int radix);
    int     l;
    longint p;
    l = 0;
    p = 1;
    for (int i = 0; i < 64; i++) begin
      if (p < width) begin
        p = p * radix;
        l = l + 1;
      end
    end
    return (l < 1) ? 1 : l;
  endfunction

  // Number of signals at tree level k (level 0 = input lanes).
  function automatic int nodes_at(input int width, input int radix,
                                  input int k);
    int n;
    n = width;
    for (int i = 0; i < k; i++) n = (n + radix - 1) / radix;
    return n;
  endfunction

  // Bit offset of level k inside the flattened level vector.
  function automatic int lvl_off(input int width, input int radix,
                                 input int k);
    int s;
    s = 0;
    for (int i = 0; i < k; i++) s = s + nodes_at(width, radix, i);
    return s;
  endfunction

endpackage

// File: rtl/reduce_r_if.sv
// reduce_r stream interface: ce, input beat (valid/op/mask/data), result.
// master drives the beat and ce; slave is the reduction pipeline.
interface reduce_r_if
  import reduce_r_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic             ce;
  logic             din_valid;
  logic [1:0]       din_op;
  logic [WIDTH-1:0] din_mask;
  logic [WIDTH-1:0] din;
  logic             dout_valid;
  logic [1:0]       dout_op;
  logic             dout;

  modport master (
    output ce, din_valid, din_op, din_mask, din,
    input  dout_valid, dout_op, dout
  );

  modport slave (
    input  ce, din_valid, din_op, din_mask, din,
    output dout_valid, dout_op, dout
  );

endinterface

// File: rtl/reduce_r_node.sv
// reduce_r_node: up-to-RADIX input registered AND/OR/XOR combiner.
// Ports: clk, srst_n, ce_i, op_i, d_i[RADIX], q_o (registered).
module reduce_r_node
  import reduce_r_pkg::*;
#(
  parameter int RADIX = 6,
  parameter bit FINAL = 1'b0
) (
  input  logic             clk,
  input  logic             srst_n,
  input  logic             ce_i,
  input  logic [1:0]       op_i,
  input  logic [RADIX-1:0] d_i,
  output logic             q_o
);

  logic q_d;
  logic q_q;

  // XNOR runs as XOR inside the tree; only the last node inverts.
  always_comb begin
    q_d = 1'b0;
    unique case (1'b1)
      (op_i == OP_AND): q_d = &d_i;
      (op_i == OP_OR):  q_d = |d_i;
      (op_i == OP_XOR): q_d = ^d_i;
      default:          q_d = FINAL ? ~^d_i : ^d_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      q_q <= 1'b0;
    end else if (ce_i) begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/reduce_r.sv
// reduce_r: pipelined masked AND/OR/XOR/XNOR reduction, LEVELS stages.
// Ports: clk, srst_n, bus (reduce_r_if.slave: ce, din_*, dout_*).
module reduce_r
  import reduce_r_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int RADIX = 6
) (
  input  logic        clk,
  input  logic        srst_n,
  reduce_r_if.slave   bus
);

  if (WIDTH < 1 || RADIX < 2 || RADIX > 6) begin : g_bad
    $fatal(1, "reduce_r: WIDTH must be >=1 and RADIX 2..6");
  end

  localparam int LEVELS = clog_radix(WIDTH, RADIX);
  localparam int TOT    = lvl_off(WIDTH, RADIX, LEVELS + 1);

  // All tree levels flattened: lanes first, final node in the MSB.
  logic [TOT-1:0]          v;
  logic [WIDTH-1:0]        lane;
  logic [LEVELS-1:0][1:0]  op_q, op_d;
  logic [LEVELS-1:0]       vld_q, vld_d;

  always_comb begin
    lane = '0;
    for (int i = 0; i < WIDTH; i++) begin
      lane[i] = bus.din_mask[i] ? bus.din[i] : id_of(bus.din_op);
    end
  end

  assign v[WIDTH-1:0] = lane;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int NIN = nodes_at(WIDTH, RADIX, k - 1);
    localparam int N   = nodes_at(WIDTH, RADIX, k);
    localparam int OI  = lvl_off(WIDTH, RADIX, k - 1);
    localparam int OO  = lvl_off(WIDTH, RADIX, k);

    // Level k works on the beat whose op sits k-2 deep in the shifter.
    logic [1:0] lop;
    if (k == 1) begin : g_op1
      assign lop = bus.din_op;
    end else begin : g_opn
      assign lop = op_q[k-2];
    end

    for (genvar j = 0; j < N; j++) begin : g_node
      logic [RADIX-1:0] d;
      for (genvar r = 0; r < RADIX; r++) begin : g_in
        if (j * RADIX + r < NIN) begin : g_real
          assign d[r] = v[OI + j*RADIX + r];
        end else begin : g_pad
          assign d[r] = id_of(lop);
        end
      end

      reduce_r_node #(
        .RADIX (RADIX),
        .FINAL (k == LEVELS)
      ) u_node (
        .clk    (clk),
        .srst_n (srst_n),
        .ce_i   (bus.ce),
        .op_i   (lop),
        .d_i    (d),
        .q_o    (v[OO + j])
      );
    end
  end

  always_comb begin
    op_d  = op_q;
    vld_d = vld_q;
    if (bus.ce) begin
      op_d[0]  = bus.din_op;
      vld_d[0] = bus.din_valid;
      for (int i = 1; i < LEVELS; i++) begin
        op_d[i]  = op_q[i-1];
        vld_d[i] = vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      op_q  <= '0;
      vld_q <= '0;
    end else begin
      op_q  <= op_d;
      vld_q <= vld_d;
    end
  end

  assign bus.dout       = v[TOT-1];
  assign bus.dout_op    = op_q[LEVELS-1];
  assign bus.dout_valid = vld_q[LEVELS-1];

endmodule
